gshare_btb_predictor: RTL and testbench
=======================================

// Module: gshare_btb_predictor
// PURPOSE
//  Parametrised gshare direction predictor with a tagged, valid-bit BTB, serving a 2-wide fetch group.
//  Fetch sends both slot PCs; one registered prediction (slot, target) returns per cycle.
//  Decode/EX resolves branches: trains PHT/GHR/BTB and raises flush + redirect on mispredict.
//  Sits between pc-select logic and the fetch/decode pipe register (flush clears that register).
// PARAMETERS
//  ADDR_W      32   PC / target width
//  BTB_DEPTH   128  BTB entries, power of 2, FIFO replacement
//  GHR_W       8    global history bits; PHT has 2**GHR_W 2-bit counters
// PORTS
//  clk          in   1       clock; all state updates on posedge
//  rst_n        in   1       asynchronous, active-low reset
//  f_valid      in   1       fetch group valid this cycle
//  f_pc0        in   ADDR_W  slot-0 PC
//  f_pc1        in   ADDR_W  slot-1 PC (normally f_pc0+4)
//  p_valid      out  1       prediction output valid (registered)
//  p_taken      out  1       a slot is predicted taken
//  p_slot       out  1       taken slot (0/1); 0 when !p_taken
//  p_target     out  ADDR_W  predicted target; 0 when !p_taken
//  p_ghr        out  GHR_W   GHR snapshot used; carried with branch down pipe
//  r_valid      in   1       branch resolution valid
//  r_pc         in   ADDR_W  resolved branch PC
//  r_ghr        in   GHR_W   p_ghr carried with that branch
//  r_pred_taken in   1       direction that was predicted
//  r_pred_tgt   in   ADDR_W  target that was predicted
//  r_taken      in   1       actual direction
//  r_target     in   ADDR_W  actual taken target
//  r_fallthru   in   ADDR_W  actual not-taken next PC
//  flush        out  1       clear fetch/decode pipe (registered, 1-cycle pulse)
//  redirect_pc  out  ADDR_W  correct next PC, valid with flush
// BEHAVIOUR
//  Reset (async, rst_n=0): p_* = 0, flush = 0, redirect_pc = 0, GHR = 0,
//    all PHT = 2'b01 (weak NT), all BTB valid = 0, replacement ptr = 0. In-flight results dropped.
//  Lookup, per slot s: idx = f_pc_s[GHR_W+1:2] ^ GHR; hit = BTB valid && tag == f_pc_s.
//    Slot taken iff hit && PHT[idx][1]. Slot 0 wins when both are taken.
//  Latency: 1 cycle; outputs registered on posedge following f_valid; p_valid=0 if !f_valid.
//  Resolve (r_valid), same-edge updates:
//    PHT[r_pc[GHR_W+1:2]^r_ghr]: sat inc if r_taken, sat dec otherwise (00 and 11 hold).
//    GHR <= {GHR[GHR_W-2:0], r_taken} (non-speculative; resolve order = program order).
//    r_taken && BTB hit on r_pc: target <= r_target. r_taken && miss: write at ptr, valid=1,
//      ptr <= ptr+1 wrapping BTB_DEPTH-1 -> 0; oldest entry overwritten when full.
//    Not-taken: no BTB allocation.
//  Mispredict = (r_pred_taken != r_taken) || (r_taken && r_pred_tgt != r_target).
//    On mispredict, next edge: flush=1, redirect_pc = r_taken ? r_target : r_fallthru.
//  Simultaneous lookup and resolve: lookup uses pre-update state (read-before-write).
//  Both fetch slots hit the same BTB entry: legal, and both read the same data.
//  Back-to-back mispredicts: flush asserted each cycle, redirect_pc from the latest one.
// CONFIGURATION
//  GBP_STATS_EN defined: adds out ports stat_lookups, stat_resolves, stat_mispred (32 bit each).
//    Counters reset to 0, saturate at 2**32-1.
//    lookups counts f_valid cycles, resolves counts r_valid, mispred counts flushes.
//  Undefined: those ports and counters are absent; all other behaviour is identical.
// TESTING
//  Reset, then f_pc0=0x100 -> p_valid=1 next cycle, p_taken=0, p_target=0.
//  Resolve r_pc=0x100 taken to 0x200, r_pred_taken=0 -> flush=1, redirect=0x200.
//    Then train PHT to >=10 -> lookup 0x100 gives p_taken=1, p_slot=0, p_target=0x200.
//  Both slots are taken-trained (0x100->0x200, 0x104->0x300) -> p_slot=0, target=0x200.
//  Allocate BTB_DEPTH+1 distinct taken branches -> first PC misses, later ones hit.
//  Predicted taken but resolved NT -> flush=1, redirect=r_fallthru; counter 11 -> 10.
//  Assert rst_n mid-stream, flush pending -> flush=0 immediately; prior BTB hits now miss.

Source files
------------

// File: rtl/gshare_btb_predictor.sv
// gshare_btb_predictor: 2-wide gshare direction predictor with fully associative FIFO BTB; define GBP_STATS_EN for stat counters
module gshare_btb_predictor #(
    parameter int ADDR_W    = 32,
    parameter int BTB_DEPTH = 128,
    parameter int GHR_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_valid,
    input  logic [ADDR_W-1:0] f_pc0,
    input  logic [ADDR_W-1:0] f_pc1,
    output logic              p_valid,
    output logic              p_taken,
    output logic              p_slot,
    output logic [ADDR_W-1:0] p_target,
    output logic [GHR_W-1:0]  p_ghr,
    input  logic              r_valid,
    input  logic [ADDR_W-1:0] r_pc,
    input  logic [GHR_W-1:0]  r_ghr,
    input  logic              r_pred_taken,
    input  logic [ADDR_W-1:0] r_pred_tgt,
    input  logic              r_taken,
    input  logic [ADDR_W-1:0] r_target,
    input  logic [ADDR_W-1:0] r_fallthru,
    output logic              flush,
    output logic [ADDR_W-1:0] redirect_pc
`ifdef GBP_STATS_EN
    ,
    output logic [31:0]       stat_lookups,
    output logic [31:0]       stat_resolves,
    output logic [31:0]       stat_mispred
`endif
);
    localparam int PHT_N = 1 << GHR_W;
    localparam int IDX_W = $clog2(BTB_DEPTH);

    logic [GHR_W-1:0]   ghr;
    logic [2*PHT_N-1:0] pht;
    logic [BTB_DEPTH-1:0] btb_valid;
    logic [ADDR_W-1:0]  btb_tag [BTB_DEPTH];
    logic [ADDR_W-1:0]  btb_tgt [BTB_DEPTH];
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   r_hit_idx;
    logic               hit0, hit1, r_hit, take0, take1, mispred;
    logic [ADDR_W-1:0]  tgt0, tgt1;
    logic [GHR_W-1:0]   idx0, idx1, r_idx;
    logic [1:0]         ctr, ctr_next;

    assign idx0     = f_pc0[GHR_W+1:2] ^ ghr;
    assign idx1     = f_pc1[GHR_W+1:2] ^ ghr;
    assign r_idx    = r_pc[GHR_W+1:2] ^ r_ghr;
    assign take0    = hit0 && pht[{idx0, 1'b1}];
    assign take1    = hit1 && pht[{idx1, 1'b1}];
    assign ctr      = pht[{r_idx, 1'b0} +: 2];
    assign ctr_next = r_taken ? (ctr == 2'b11 ? ctr : ctr + 2'd1) : (ctr == 2'b00 ? ctr : ctr - 2'd1);
    assign mispred  = r_valid && ((r_pred_taken != r_taken) || (r_taken && r_pred_tgt != r_target));

    // Allocation only happens on a miss, so at most one entry matches any PC.
    always_comb begin
        hit0      = 1'b0;
        hit1      = 1'b0;
        r_hit     = 1'b0;
        tgt0      = '0;
        tgt1      = '0;
        r_hit_idx = '0;
        for (int i = 0; i < BTB_DEPTH; i++) begin
            if (btb_valid[i] && btb_tag[i] == f_pc0) begin
                hit0 = 1'b1;
                tgt0 = btb_tgt[i];
            end
            if (btb_valid[i] && btb_tag[i] == f_pc1) begin
                hit1 = 1'b1;
                tgt1 = btb_tgt[i];
            end
            if (btb_valid[i] && btb_tag[i] == r_pc) begin
                r_hit     = 1'b1;
                r_hit_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid     <= 1'b0;
            p_taken     <= 1'b0;
            p_slot      <= 1'b0;
            p_target    <= '0;
            p_ghr       <= '0;
            flush       <= 1'b0;
            redirect_pc <= '0;
            ghr         <= '0;
            pht         <= {PHT_N{2'b01}};
            btb_valid   <= '0;
            ptr         <= '0;
        end else begin
            p_valid     <= f_valid;
            p_taken     <= f_valid && (take0 || take1);
            p_slot      <= f_valid && !take0 && take1;
            p_target    <= !f_valid ? '0 : take0 ? tgt0 : take1 ? tgt1 : '0;
            p_ghr       <= f_valid ? ghr : '0;
            flush       <= mispred;
            redirect_pc <= !mispred ? '0 : r_taken ? r_target : r_fallthru;
            if (r_valid) begin
                pht[{r_idx, 1'b0} +: 2] <= ctr_next;
                ghr <= {ghr[GHR_W-2:0], r_taken};
                if (r_taken && !r_hit) begin
                    btb_valid[ptr] <= 1'b1;
                    ptr            <= ptr + IDX_W'(1);
                end
            end
        end
    end

    // Tag/target storage needs no reset: entries are gated by btb_valid.
    always_ff @(posedge clk) begin
        if (r_valid && r_taken) begin
            if (r_hit) begin
                btb_tgt[r_hit_idx] <= r_target;
            end else begin
                btb_tag[ptr] <= r_pc;
                btb_tgt[ptr] <= r_target;
            end
        end
    end

`ifdef GBP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_lookups  <= '0;
            stat_resolves <= '0;
            stat_mispred  <= '0;
        end else begin
            if (f_valid && stat_lookups != '1) stat_lookups <= stat_lookups + 32'd1;
            if (r_valid && stat_resolves != '1) stat_resolves <= stat_resolves + 32'd1;
            if (flush && stat_mispred != '1) stat_mispred <= stat_mispred + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_gshare_btb_predictor.sv
// tb_gshare_btb_predictor: directed vector table plus hand sequences for the gshare/BTB predictor
module tb_gshare_btb_predictor;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_valid;
    logic [31:0] f_pc0, f_pc1;
    logic        p_valid, p_taken, p_slot;
    logic [31:0] p_target;
    logic [7:0]  p_ghr;
    logic        r_valid;
    logic [31:0] r_pc;
    logic [7:0]  r_ghr;
    logic        r_pred_taken;
    logic [31:0] r_pred_tgt;
    logic        r_taken;
    logic [31:0] r_target, r_fallthru;
    logic        flush;
    logic [31:0] redirect_pc;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] fv, pc0, pc1, rv, rpc, rghr, rpt, rptgt, rt, rtgt, rft;
        logic [31:0] pv, pt, ps, ptgt, pghr, fl, rd;
    } vec_t;

    vec_t vecs [19];

    gshare_btb_predictor dut (
        .clk(clk), .rst_n(rst_n), .f_valid(f_valid), .f_pc0(f_pc0), .f_pc1(f_pc1),
        .p_valid(p_valid), .p_taken(p_taken), .p_slot(p_slot), .p_target(p_target), .p_ghr(p_ghr),
        .r_valid(r_valid), .r_pc(r_pc), .r_ghr(r_ghr), .r_pred_taken(r_pred_taken),
        .r_pred_tgt(r_pred_tgt), .r_taken(r_taken), .r_target(r_target), .r_fallthru(r_fallthru),
        .flush(flush), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        f_valid = 1'b0; f_pc0 = '0; f_pc1 = '0;
        r_valid = 1'b0; r_pc = '0; r_ghr = '0; r_pred_taken = 1'b0;
        r_pred_tgt = '0; r_taken = 1'b0; r_target = '0; r_fallthru = '0;
    endtask

    task automatic drive(input vec_t v);
        f_valid = v.fv[0]; f_pc0 = v.pc0; f_pc1 = v.pc1;
        r_valid = v.rv[0]; r_pc = v.rpc; r_ghr = v.rghr[7:0]; r_pred_taken = v.rpt[0];
        r_pred_tgt = v.rptgt; r_taken = v.rt[0]; r_target = v.rtgt; r_fallthru = v.rft;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic [7:0] g, input logic pt,
                           input logic [31:0] ptg, input logic t, input logic [31:0] tg,
                           input logic [31:0] ft);
        idle();
        r_valid = 1'b1; r_pc = pc; r_ghr = g; r_pred_taken = pt;
        r_pred_tgt = ptg; r_taken = t; r_target = tg; r_fallthru = ft;
        tick();
        idle();
    endtask

    task automatic lookup(input logic [31:0] pc);
        idle();
        f_valid = 1'b1; f_pc0 = pc; f_pc1 = 32'hF00;
        tick();
        idle();
    endtask

    task automatic restore_ghr();
        for (int k = 0; k < 8; k++) resolve(32'h104, 8'h00, 1'b1, 32'h300, 1'b1, 32'h300, 32'h108);
    endtask

    initial begin
        vecs[0]  = '{1,'h100,'h104, 0,0,0,0,0,0,0,0,               1,0,0,0,'h00,0,0};
        vecs[1]  = '{0,0,0, 1,'h100,0,0,0,1,'h200,'h104,           0,0,0,0,0,1,'h200};
        vecs[2]  = '{1,'h100,'h104, 1,'h100,'hFF,1,'h200,1,'h200,'h104, 1,0,0,0,'h01,0,0};
        for (int k = 3; k <= 9; k++)
            vecs[k] = '{0,0,0, 1,'h100,'hFF,1,'h200,1,'h200,'h104, 0,0,0,0,0,0,0};
        vecs[10] = '{1,'h100,'h104, 0,0,0,0,0,0,0,0,               1,1,0,'h200,'hFF,0,0};
        vecs[11] = '{1,'h104,'h108, 1,'h104,'hFF,0,0,1,'h300,'h108, 1,0,0,0,'hFF,1,'h300};
        vecs[12] = '{1,'h104,'h108, 1,'h104,'hFF,1,'h300,1,'h300,'h108, 1,1,0,'h300,'hFF,0,0};
        vecs[13] = '{1,'h100,'h104, 0,0,0,0,0,0,0,0,               1,1,0,'h200,'hFF,0,0};
        vecs[14] = '{1,'hFC,'h100, 0,0,0,0,0,0,0,0,                1,1,1,'h200,'hFF,0,0};
        vecs[15] = '{1,'h100,'h100, 0,0,0,0,0,0,0,0,               1,1,0,'h200,'hFF,0,0};
        vecs[16] = '{1,'h100,'h104, 1,'h100,'hFF,1,'h200,1,'h280,'h104, 1,1,0,'h200,'hFF,1,'h280};
        vecs[17] = '{1,'h100,'h104, 0,0,0,0,0,0,0,0,               1,1,0,'h280,'hFF,0,0};
        vecs[18] = '{0,0,0, 0,0,0,0,0,0,0,0,                       0,0,0,0,0,0,0};

        idle();
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst.pv", {31'b0, p_valid}, 0);
        chk("rst.pt", {31'b0, p_taken}, 0);
        chk("rst.ptgt", p_target, 0);
        chk("rst.fl", {31'b0, flush}, 0);
        chk("rst.rd", redirect_pc, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i]);
            tick();
            chk($sformatf("v%0d.pv", i), {31'b0, p_valid}, vecs[i].pv);
            chk($sformatf("v%0d.pt", i), {31'b0, p_taken}, vecs[i].pt);
            chk($sformatf("v%0d.ps", i), {31'b0, p_slot}, vecs[i].ps);
            chk($sformatf("v%0d.ptgt", i), p_target, vecs[i].ptgt);
            if (vecs[i].pv[0]) chk($sformatf("v%0d.pghr", i), {24'b0, p_ghr}, vecs[i].pghr);
            chk($sformatf("v%0d.fl", i), {31'b0, flush}, vecs[i].fl);
            chk($sformatf("v%0d.rd", i), redirect_pc, vecs[i].rd);
        end

        // predicted taken, resolved not-taken: 11 -> 10 (still taken), then 10 -> 01
        for (int n = 0; n < 2; n++) begin
            resolve(32'h100, 8'hFF, 1'b1, 32'h280, 1'b0, 32'h0, 32'h104);
            chk($sformatf("nt%0d.fl", n), {31'b0, flush}, 1);
            chk($sformatf("nt%0d.rd", n), redirect_pc, 32'h104);
            restore_ghr();
            lookup(32'h100);
            chk($sformatf("nt%0d.pt", n), {31'b0, p_taken}, n == 0 ? 1 : 0);
            chk($sformatf("nt%0d.ptgt", n), p_target, n == 0 ? 32'h280 : 32'h0);
        end

        resolve(32'h400, 8'h00, 1'b0, 32'h0, 1'b1, 32'h500, 32'h404);
        chk("b2b0.fl", {31'b0, flush}, 1);
        chk("b2b0.rd", redirect_pc, 32'h500);
        resolve(32'h404, 8'h00, 1'b1, 32'h600, 1'b0, 32'h0, 32'h408);
        chk("b2b1.fl", {31'b0, flush}, 1);
        chk("b2b1.rd", redirect_pc, 32'h408);
        tick();
        chk("b2b2.fl", {31'b0, flush}, 0);

        // BTB_DEPTH+1 distinct taken branches evict every older entry
        for (int k = 0; k <= 128; k++)
            resolve(32'h10000 + 4*k, 8'hFF, 1'b0, 32'h0, 1'b1, 32'h20000 + 4*k, 32'h10004 + 4*k);
        lookup(32'h10000);
        chk("ovf.first.pt", {31'b0, p_taken}, 0);
        lookup(32'h10004);
        chk("ovf.k1.pt", {31'b0, p_taken}, 1);
        chk("ovf.k1.tgt", p_target, 32'h20004);
        lookup(32'h10100);
        chk("ovf.k64.tgt", p_target, 32'h20100);
        lookup(32'h10200);
        chk("ovf.k128.pt", {31'b0, p_taken}, 1);
        chk("ovf.k128.tgt", p_target, 32'h20200);
        lookup(32'h100);
        chk("ovf.old100.pt", {31'b0, p_taken}, 0);
        lookup(32'h400);
        chk("ovf.old400.pt", {31'b0, p_taken}, 0);

        // async reset while a flush is pending
        idle();
        f_valid = 1'b1; f_pc0 = 32'h10004; f_pc1 = 32'hF00;
        r_valid = 1'b1; r_pc = 32'h500; r_taken = 1'b1; r_target = 32'h600; r_fallthru = 32'h504;
        tick();
        idle();
        chk("mid.fl", {31'b0, flush}, 1);
        chk("mid.pt", {31'b0, p_taken}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.fl", {31'b0, flush}, 0);
        chk("arst.rd", redirect_pc, 0);
        chk("arst.pv", {31'b0, p_valid}, 0);
        chk("arst.pt", {31'b0, p_taken}, 0);
        chk("arst.ptgt", p_target, 0);
        tick();
        rst_n = 1'b1;
        lookup(32'h10004);
        chk("post.pv", {31'b0, p_valid}, 1);
        chk("post.pt", {31'b0, p_taken}, 0);
        chk("post.pghr", {24'b0, p_ghr}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
